// File: rtl/nand_gate_out_responder_pkg.sv
// Shared types, reset constants and sizing helpers for the nand_gate_out responder.
package nand_gate_out_pkg_hdl;

  localparam int unsigned NAND_GATE_IN_WIDTH = 8;

  typedef logic [NAND_GATE_IN_WIDTH-1:0] nand_gate_out_data_t;

  localparam nand_gate_out_data_t Y_RST         = '0;
  localparam int unsigned         TXN_COUNT_RST = 0;

  // Occupancy must represent 0..depth inclusive, hence one bit more than the pointer.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nand_gate_out_responder_fifo.sv
// Synchronous result FIFO: power-of-two depth, free-running wrapping pointers, explicit level.
module nand_gate_out_fifo
  import nand_gate_out_pkg_hdl::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LW    = level_width(DEPTH),
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  // NOTE: storage has no reset; stale entries are unreachable because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wptr] <= din;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/nand_gate_out_responder.sv
// Accepts a/b operands, buffers ~(a & b) in a FIFO and presents results on a valid/ready channel.
module nand_gate_out_responder
  import nand_gate_out_pkg_hdl::*;
#(
  parameter  int unsigned nand_gate_in_WIDTH = 8,
  parameter  int unsigned DEPTH              = 4,
  parameter  int unsigned COUNT_WIDTH        = 16,
  localparam int unsigned LW                 = level_width(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [nand_gate_in_WIDTH-1:0] a,
  input  logic [nand_gate_in_WIDTH-1:0] b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [nand_gate_in_WIDTH-1:0] y,
  output logic [LW-1:0]                 level,
  output logic [COUNT_WIDTH-1:0]        txn_count
);

  logic [nand_gate_in_WIDTH-1:0] result;
  logic [nand_gate_in_WIDTH-1:0] head;
  logic                          full;
  logic                          empty;
  logic                          accept;
  logic                          consume;

  // in_ready depends only on registered occupancy, so a pop frees space one cycle later.
  assign in_ready  = ~rst & ~full;
  assign out_valid = ~empty;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign result    = ~(a & b);
  assign y         = out_valid ? head : nand_gate_in_WIDTH'(Y_RST);

  nand_gate_out_fifo #(
    .WIDTH (nand_gate_in_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (result),
    .pop   (consume),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst)          txn_count <= COUNT_WIDTH'(TXN_COUNT_RST);
    else if (consume) txn_count <= txn_count + COUNT_WIDTH'(1);
  end

endmodule
